// File: rtl/rv32i_types.sv
// Shared RV32I types: register index, opcode encodings and the hazard controller state.
package rv32i_types;

  typedef logic [4:0] rv32i_reg;

  typedef enum logic [6:0] {
    op_lui   = 7'b0110111,
    op_auipc = 7'b0010111,
    op_jal   = 7'b1101111,
    op_jalr  = 7'b1100111,
    op_br    = 7'b1100011,
    op_load  = 7'b0000011,
    op_store = 7'b0100011,
    op_imm   = 7'b0010011,
    op_reg   = 7'b0110011,
    op_csr   = 7'b1110011
  } rv32i_opcode;

  typedef enum logic {
    RUN       = 1'b0,
    LU_BUBBLE = 1'b1
  } hazard_state_t;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard decode between the EX load and the ID instruction.
module load_use_detect
  import rv32i_types::*;
(
  input  rv32i_reg    id_rs1,
  input  rv32i_reg    id_rs2,
  input  rv32i_opcode id_opcode,
  input  rv32i_reg    id_ex_rd,
  input  logic        id_ex_mem_read,
  output logic        ld_use
);

  logic uses_rs1;
  logic uses_rs2;

  always_comb begin
    uses_rs1 = !(id_opcode inside {op_lui, op_auipc, op_jal});
    uses_rs2 = id_opcode inside {op_reg, op_br, op_store};
    ld_use   = id_ex_mem_read && (id_ex_rd != '0) &&
               (((id_ex_rd == id_rs1) && uses_rs1) ||
                ((id_ex_rd == id_rs2) && uses_rs2));
  end

endmodule

// File: rtl/hazard_controller.sv
// Pipeline hazard controller: freeze > branch flush > load-use bubble.
// Performance counters are built only when HAZARD_PERF_CNT_EN is defined.
module hazard_controller
  import rv32i_types::*;
(
  input  logic        clk,
  input  logic        rst,
  input  rv32i_reg    id_rs1,
  input  rv32i_reg    id_rs2,
  input  rv32i_opcode id_opcode,
  input  rv32i_reg    id_ex_rd,
  input  logic        id_ex_mem_read,
  input  logic        ex_br_taken,
  input  logic        imem_resp,
  input  logic        dmem_req,
  input  logic        dmem_resp,
  output logic        pc_stall,
  output logic        if_id_stall,
  output logic        id_ex_stall,
  output logic        ex_mem_stall,
  output logic        mem_wb_stall,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic [31:0] ld_use_cnt,
  output logic [31:0] mem_stall_cnt,
  output logic [31:0] flush_cnt
);

  hazard_state_t state;
  logic ld_use;
  logic freeze;
  logic do_flush;
  logic do_bubble;

  load_use_detect u_load_use_detect (
    .id_rs1         (id_rs1),
    .id_rs2         (id_rs2),
    .id_opcode      (id_opcode),
    .id_ex_rd       (id_ex_rd),
    .id_ex_mem_read (id_ex_mem_read),
    .ld_use         (ld_use)
  );

  always_comb begin
    freeze    = !imem_resp || (dmem_req && !dmem_resp);
    do_flush  = !freeze && ex_br_taken;
    do_bubble = !freeze && !ex_br_taken && ld_use && (state == RUN);

    // Outputs are forced quiet during reset regardless of the other inputs.
    pc_stall     = !rst && (freeze || do_bubble);
    if_id_stall  = !rst && (freeze || do_bubble);
    id_ex_stall  = !rst && freeze;
    ex_mem_stall = !rst && freeze;
    mem_wb_stall = !rst && freeze;
    if_id_flush  = !rst && do_flush;
    id_ex_flush  = !rst && (do_flush || do_bubble);
  end

  always_ff @(posedge clk) begin
    if (rst)            state <= RUN;
    else if (freeze)    state <= state;
    else if (do_bubble) state <= LU_BUBBLE;
    else                state <= RUN;
  end

`ifdef HAZARD_PERF_CNT_EN
  generate
    if (1'b1) begin : g_perf_cnt
      logic [31:0] lu_q;
      logic [31:0] ms_q;
      logic [31:0] fl_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          lu_q <= '0;
          ms_q <= '0;
          fl_q <= '0;
        end else begin
          if (do_bubble) lu_q <= lu_q + 32'd1;
          if (freeze)    ms_q <= ms_q + 32'd1;
          if (do_flush)  fl_q <= fl_q + 32'd1;
        end
      end

      assign ld_use_cnt    = lu_q;
      assign mem_stall_cnt = ms_q;
      assign flush_cnt     = fl_q;
    end
  endgenerate
`else
  assign ld_use_cnt    = '0;
  assign mem_stall_cnt = '0;
  assign flush_cnt     = '0;
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// Scoreboard bench for hazard_controller; counter expectations follow HAZARD_PERF_CNT_EN.
module tb_hazard_controller;
  import rv32i_types::*;

  logic        clk = 1'b0;
  logic        rst;
  rv32i_reg    id_rs1, id_rs2, id_ex_rd;
  rv32i_opcode id_opcode;
  logic        id_ex_mem_read, ex_br_taken, imem_resp, dmem_req, dmem_resp;
  logic        pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, mem_wb_stall;
  logic        if_id_flush, id_ex_flush;
  logic [31:0] ld_use_cnt, mem_stall_cnt, flush_cnt;

  hazard_controller dut (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_opcode(id_opcode),
    .id_ex_rd(id_ex_rd), .id_ex_mem_read(id_ex_mem_read), .ex_br_taken(ex_br_taken),
    .imem_resp(imem_resp), .dmem_req(dmem_req), .dmem_resp(dmem_resp),
    .pc_stall(pc_stall), .if_id_stall(if_id_stall), .id_ex_stall(id_ex_stall),
    .ex_mem_stall(ex_mem_stall), .mem_wb_stall(mem_wb_stall),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .ld_use_cnt(ld_use_cnt), .mem_stall_cnt(mem_stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  int unsigned total = 0;
  int unsigned bad   = 0;
  logic [6:0]  sb[$];
  logic [6:0]  exp_v;
  bit          m_bubble = 1'b0;
  logic [31:0] m_lu = '0, m_ms = '0, m_fl = '0;
  rv32i_opcode ops[10];

  // {pc, if_id, id_ex, ex_mem, mem_wb stalls, if_id_flush, id_ex_flush}
  function automatic logic [6:0] outs();
    return {pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, mem_wb_stall,
            if_id_flush, id_ex_flush};
  endfunction

  function automatic bit m_ld_use();
    bit u1, u2;
    u1 = !(id_opcode == op_lui || id_opcode == op_auipc || id_opcode == op_jal);
    u2 = (id_opcode == op_reg || id_opcode == op_br || id_opcode == op_store);
    return id_ex_mem_read && id_ex_rd != 5'd0 &&
           ((id_ex_rd == id_rs1 && u1) || (id_ex_rd == id_rs2 && u2));
  endfunction

  function automatic bit m_freeze();
    return !imem_resp || (dmem_req && !dmem_resp);
  endfunction

  // Drive one cycle of inputs and push the expected combinational outputs.
  task automatic drive(input logic r, input rv32i_reg rs1, input rv32i_reg rs2,
                       input rv32i_opcode op, input rv32i_reg rd, input logic mr,
                       input logic br, input logic im, input logic dq, input logic dp);
    logic [6:0] e;
    rst = r; id_rs1 = rs1; id_rs2 = rs2; id_opcode = op; id_ex_rd = rd;
    id_ex_mem_read = mr; ex_br_taken = br; imem_resp = im; dmem_req = dq; dmem_resp = dp;
    if (r)                             e = 7'b0000000;
    else if (m_freeze())               e = 7'b1111100;
    else if (br)                       e = 7'b0000011;
    else if (m_ld_use() && !m_bubble)  e = 7'b1100001;
    else                               e = 7'b0000000;
    sb.push_back(e);
    #4;
  endtask

  // Clock edge: advance the reference state machine and counters.
  task automatic advance();
    bit fz, lu;
    @(posedge clk);
    fz = m_freeze();
    lu = m_ld_use();
    if (rst) begin
      m_bubble = 1'b0; m_lu = '0; m_ms = '0; m_fl = '0;
    end else if (fz) begin
`ifdef HAZARD_PERF_CNT_EN
      m_ms = m_ms + 32'd1;
`endif
    end else if (ex_br_taken) begin
      m_bubble = 1'b0;
`ifdef HAZARD_PERF_CNT_EN
      m_fl = m_fl + 32'd1;
`endif
    end else if (lu && !m_bubble) begin
      m_bubble = 1'b1;
`ifdef HAZARD_PERF_CNT_EN
      m_lu = m_lu + 32'd1;
`endif
    end else begin
      m_bubble = 1'b0;
    end
    #1;
  endtask

  task automatic test_reset();
    drive(1, 5'd5, 5'd0, op_reg, 5'd5, 1, 1, 0, 1, 0);
    exp_v = sb.pop_front(); total++;
    if (outs() !== exp_v) begin bad++; $display("FAIL reset_outs got=%b want=%b", outs(), exp_v); end
    advance();
    drive(1, 5'd0, 5'd0, op_imm, 5'd0, 0, 0, 1, 0, 0);
    exp_v = sb.pop_front(); total++;
    if (outs() !== exp_v) begin bad++; $display("FAIL reset_outs2 got=%b want=%b", outs(), exp_v); end
    advance();
    total++;
    if ({ld_use_cnt, mem_stall_cnt, flush_cnt} !== {m_lu, m_ms, m_fl}) begin
      bad++; $display("FAIL reset_cnt got=%h/%h/%h want=%h/%h/%h",
                      ld_use_cnt, mem_stall_cnt, flush_cnt, m_lu, m_ms, m_fl);
    end
  endtask

  task automatic test_load_use();
    for (int i = 0; i < 3; i++) begin
      drive(0, 5'd5, 5'd7, op_reg, 5'd5, (i < 2), 0, 1, 0, 0);
      exp_v = sb.pop_front(); total++;
      if (outs() !== exp_v) begin bad++; $display("FAIL load_use_c%0d got=%b want=%b", i, outs(), exp_v); end
      advance();
    end
    total++;
    if (ld_use_cnt !== m_lu) begin bad++; $display("FAIL ld_use_cnt got=%0d want=%0d", ld_use_cnt, m_lu); end
  endtask

  task automatic test_no_hazard();
    // x0 dest, lui ignoring rs1, imm ignoring rs2, then store using rs2 (hazard)
    rv32i_opcode op_t[4];
    rv32i_reg    rd_t[4];
    op_t = '{op_reg, op_lui, op_imm, op_store};
    rd_t = '{5'd0, 5'd3, 5'd9, 5'd9};
    for (int i = 0; i < 4; i++) begin
      drive(0, (i == 1) ? 5'd3 : 5'd0, (i >= 2) ? 5'd9 : 5'd0, op_t[i], rd_t[i], 1, 0, 1, 0, 0);
      exp_v = sb.pop_front(); total++;
      if (outs() !== exp_v) begin bad++; $display("FAIL no_hazard_%0d got=%b want=%b", i, outs(), exp_v); end
      advance();
    end
    drive(0, 5'd0, 5'd0, op_imm, 5'd0, 0, 0, 1, 0, 0);
    exp_v = sb.pop_front(); total++;
    if (outs() !== exp_v) begin bad++; $display("FAIL no_hazard_idle got=%b want=%b", outs(), exp_v); end
    advance();
  endtask

  task automatic test_mem_freeze();
    for (int i = 0; i < 4; i++) begin
      drive(0, 5'd1, 5'd2, op_reg, 5'd4, 0, 0, 1, 1, (i == 3));
      exp_v = sb.pop_front(); total++;
      if (outs() !== exp_v) begin bad++; $display("FAIL mem_freeze_c%0d got=%b want=%b", i, outs(), exp_v); end
      advance();
    end
    total++;
    if (mem_stall_cnt !== m_ms) begin bad++; $display("FAIL mem_stall_cnt got=%0d want=%0d", mem_stall_cnt, m_ms); end
  endtask

  task automatic test_branch_ld_use();
    for (int i = 0; i < 3; i++) begin
      drive(0, 5'd6, 5'd0, op_imm, 5'd6, (i < 2), (i == 0), 1, 0, 0);
      exp_v = sb.pop_front(); total++;
      if (outs() !== exp_v) begin bad++; $display("FAIL branch_ld_use_c%0d got=%b want=%b", i, outs(), exp_v); end
      advance();
    end
    total++;
    if (flush_cnt !== m_fl) begin bad++; $display("FAIL flush_cnt got=%0d want=%0d", flush_cnt, m_fl); end
  endtask

  task automatic test_freeze_defers();
    for (int i = 0; i < 4; i++) begin
      drive(0, 5'd2, 5'd8, op_br, 5'd8, (i < 3), 0, (i != 0), 0, 0);
      exp_v = sb.pop_front(); total++;
      if (outs() !== exp_v) begin bad++; $display("FAIL freeze_defer_c%0d got=%b want=%b", i, outs(), exp_v); end
      advance();
    end
  endtask

  task automatic test_back_to_back();
    // bubble, branch while in bubble, then a fresh load-use bubbles again
    for (int i = 0; i < 4; i++) begin
      drive(0, 5'd10, 5'd0, op_load, 5'd10, 1, (i == 1), 1, 0, 0);
      exp_v = sb.pop_front(); total++;
      if (outs() !== exp_v) begin bad++; $display("FAIL back_to_back_c%0d got=%b want=%b", i, outs(), exp_v); end
      advance();
    end
  endtask

  task automatic test_reset_in_bubble();
    for (int i = 0; i < 4; i++) begin
      drive((i == 1), 5'd11, 5'd0, op_jalr, 5'd11, 1, 0, 1, (i == 1), 0);
      exp_v = sb.pop_front(); total++;
      if (outs() !== exp_v) begin bad++; $display("FAIL rst_bubble_c%0d got=%b want=%b", i, outs(), exp_v); end
      advance();
      if (i == 1) begin
        total++;
        if ({ld_use_cnt, mem_stall_cnt, flush_cnt} !== 96'd0) begin
          bad++; $display("FAIL rst_bubble_cnt got=%h/%h/%h want=0/0/0",
                          ld_use_cnt, mem_stall_cnt, flush_cnt);
        end
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      drive(($urandom_range(0, 49) == 0), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            ops[$urandom_range(0, 9)], 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 7) == 0), ($urandom_range(0, 5) != 0),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      exp_v = sb.pop_front(); total++;
      if (outs() !== exp_v) begin bad++; $display("FAIL random_%0d got=%b want=%b", i, outs(), exp_v); end
      advance();
    end
    total++;
    if ({ld_use_cnt, mem_stall_cnt, flush_cnt} !== {m_lu, m_ms, m_fl}) begin
      bad++; $display("FAIL random_cnt got=%h/%h/%h want=%h/%h/%h",
                      ld_use_cnt, mem_stall_cnt, flush_cnt, m_lu, m_ms, m_fl);
    end
  endtask

  initial begin
    ops = '{op_lui, op_auipc, op_jal, op_jalr, op_br, op_load, op_store, op_imm, op_reg, op_csr};
    rst = 1'b1; id_rs1 = '0; id_rs2 = '0; id_opcode = op_imm; id_ex_rd = '0;
    id_ex_mem_read = 1'b0; ex_br_taken = 1'b0; imem_resp = 1'b1; dmem_req = 1'b0; dmem_resp = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_load_use();
    test_no_hazard();
    test_mem_freeze();
    test_branch_ld_use();
    test_freeze_defers();
    test_back_to_back();
    test_reset_in_bubble();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
